// File: rtl/i_decode.sv
// Instruction-decode stage for the single-cycle LEGv8 datapath: main control
// decode, sign-extended immediate, and the 32 x 64-bit register file.
module i_decode #(
    parameter int unsigned WORD      = 64,
    parameter int unsigned INSTR_LEN = 32,
    parameter int unsigned NREGS     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INSTR_LEN-1:0] instr,
    input  logic [WORD-1:0]      write_data,
    output logic [WORD-1:0]      read_data1,
    output logic [WORD-1:0]      read_data2,
    output logic [WORD-1:0]      ext_addr,
    output logic                 uncondbranch,
    output logic                 branch,
    output logic                 mem_read,
    output logic                 mem_to_reg,
    output logic                 mem_write,
    output logic                 alu_src,
    output logic                 reg_write,
    output logic [1:0]           alu_op
);

    localparam int unsigned OPC_W   = 11;
    localparam int unsigned REG_AW  = $clog2(NREGS);
    localparam int unsigned D_IMM_W = 9;
    localparam int unsigned CB_IMM_W = 19;
    localparam int unsigned B_IMM_W = 26;

    localparam logic [OPC_W-1:0] OPC_LDUR = 11'b111_1100_0010;
    localparam logic [OPC_W-1:0] OPC_STUR = 11'b111_1100_0000;
    localparam logic [OPC_W-1:0] OPC_ADD  = 11'b100_0101_1000;
    localparam logic [OPC_W-1:0] OPC_SUB  = 11'b110_0101_1000;
    localparam logic [OPC_W-1:0] OPC_AND  = 11'b100_0101_0000;
    localparam logic [OPC_W-1:0] OPC_ORR  = 11'b101_0101_0000;
    localparam logic [7:0]       OPC_CBZ  = 8'b1011_0100;
    localparam logic [5:0]       OPC_B    = 6'b00_0101;

    localparam logic [REG_AW-1:0] XZR = REG_AW'(NREGS - 1);

    logic [OPC_W-1:0]  opcode;
    logic              is_ldur;
    logic              is_stur;
    logic              is_rtype;
    logic              is_cbz;
    logic              is_b;
    logic              reg2_loc;
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] rm;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs2;

    logic [WORD-1:0] regs [NREGS];

    assign opcode = instr[31:21];

    // Instruction class recognition
    always_comb begin
        is_ldur  = (opcode == OPC_LDUR);
        is_stur  = (opcode == OPC_STUR);
        is_rtype = (opcode == OPC_ADD) || (opcode == OPC_SUB) ||
                   (opcode == OPC_AND) || (opcode == OPC_ORR);
        is_cbz   = (instr[31:24] == OPC_CBZ);
        is_b     = (instr[31:26] == OPC_B);
    end

    // Main control decode; anything unrecognised leaves every control low
    always_comb begin
        uncondbranch = 1'b0;
        branch       = 1'b0;
        mem_read     = 1'b0;
        mem_to_reg   = 1'b0;
        mem_write    = 1'b0;
        alu_src      = 1'b0;
        reg_write    = 1'b0;
        alu_op       = 2'b00;
        if (is_ldur) begin
            alu_src    = 1'b1;
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            mem_read   = 1'b1;
        end else if (is_stur) begin
            alu_src   = 1'b1;
            mem_write = 1'b1;
        end else if (is_rtype) begin
            reg_write = 1'b1;
            alu_op    = 2'b10;
        end else if (is_cbz) begin
            branch = 1'b1;
            alu_op = 2'b01;
        end else if (is_b) begin
            uncondbranch = 1'b1;
        end
    end

    // Immediate field selection and sign extension to the full datapath width
    always_comb begin
        ext_addr = '0;
        if (is_ldur || is_stur) begin
            ext_addr = {{(WORD - D_IMM_W){instr[20]}}, instr[20:12]};
        end else if (is_cbz) begin
            ext_addr = {{(WORD - CB_IMM_W){instr[23]}}, instr[23:5]};
        end else if (is_b) begin
            ext_addr = {{(WORD - B_IMM_W){instr[25]}}, instr[25:0]};
        end
    end

    // Rt lives in instr[4:0] for stores and CBZ, Rm in instr[20:16] otherwise
    assign reg2_loc = instr[28];
    assign rn  = REG_AW'(instr[9:5]);
    assign rm  = REG_AW'(instr[20:16]);
    assign rd  = REG_AW'(instr[4:0]);
    assign rs2 = reg2_loc ? rd : rm;

    // Asynchronous reads; XZR is forced to zero regardless of storage
    always_comb begin
        read_data1 = (rn == XZR)  ? '0 : regs[rn];
        read_data2 = (rs2 == XZR) ? '0 : regs[rs2];
    end

    // Write-back port; reset clears the file and suppresses the write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (reg_write && (rd != XZR)) begin
            regs[rd] <= write_data;
        end
    end

endmodule

// File: tb/tb_i_decode.sv
// Directed bench for i_decode: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_i_decode;

    localparam int unsigned WORD = 64;

    // Packed control vector: {uncond, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}
    localparam logic [8:0] C_NONE = 9'b0_0_0_0_0_0_0_00;
    localparam logic [8:0] C_R    = 9'b0_0_0_0_0_0_1_10;
    localparam logic [8:0] C_LDUR = 9'b0_0_1_1_0_1_1_00;
    localparam logic [8:0] C_STUR = 9'b0_0_0_0_1_1_0_00;
    localparam logic [8:0] C_CBZ  = 9'b0_1_0_0_0_0_0_01;
    localparam logic [8:0] C_B    = 9'b1_0_0_0_0_0_0_00;

    localparam int SEL_RD1  = 0;
    localparam int SEL_RD2  = 1;
    localparam int SEL_EXT  = 2;
    localparam int SEL_CTRL = 3;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     instr;
    logic [WORD-1:0] write_data;
    logic [WORD-1:0] read_data1;
    logic [WORD-1:0] read_data2;
    logic [WORD-1:0] ext_addr;
    logic            uncondbranch;
    logic            branch;
    logic            mem_read;
    logic            mem_to_reg;
    logic            mem_write;
    logic            alu_src;
    logic            reg_write;
    logic [1:0]      alu_op;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    i_decode dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .write_data   (write_data),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .ext_addr     (ext_addr),
        .uncondbranch (uncondbranch),
        .branch       (branch),
        .mem_read     (mem_read),
        .mem_to_reg   (mem_to_reg),
        .mem_write    (mem_write),
        .alu_src      (alu_src),
        .reg_write    (reg_write),
        .alu_op       (alu_op)
    );

    function automatic logic [63:0] actual(input int sel);
        case (sel)
            SEL_RD1: actual = read_data1;
            SEL_RD2: actual = read_data2;
            SEL_EXT: actual = ext_addr;
            default: actual = 64'({uncondbranch, branch, mem_read, mem_to_reg,
                                   mem_write, alu_src, reg_write, alu_op});
        endcase
    endfunction

    // Monitor: outputs are combinational, so sample mid-cycle on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() != 0) begin
                exp_t e;
                logic [63:0] a;
                e = sb.pop_front();
                a = actual(e.sel);
                checks++;
                if (a !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%h expected 0x%h", e.name, a, e.exp);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [63:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        sb.push_back(e);
    endtask

    // Apply one instruction just after a rising edge; its write commits at the next edge
    task automatic step(input logic rst, input logic [31:0] ins, input logic [63:0] wd);
        @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        #1;
        reset      = rst;
        instr      = ins;
        write_data = wd;
    endtask

    initial begin
        reset      = 1'b1;
        instr      = 32'h0;
        write_data = 64'd0;

        step(1'b1, 32'h0000_0000, 64'd0);
        expect_val("rst_ctrl", SEL_CTRL, 64'(C_NONE));
        step(1'b1, 32'h0000_0000, 64'd0);
        expect_val("unknown_ext", SEL_EXT, 64'd0);

        // ADD X3,X1,X2 right after reset
        step(1'b0, 32'h8B02_0023, 64'd0);
        expect_val("add_rd1", SEL_RD1, 64'd0);
        expect_val("add_rd2", SEL_RD2, 64'd0);
        expect_val("add_ctrl", SEL_CTRL, 64'(C_R));

        // LDUR X1,[X31,#0] writes 20 at the next edge; same-cycle read sees old X1
        step(1'b0, 32'hF840_03E1, 64'd20);
        expect_val("ldur_ctrl", SEL_CTRL, 64'(C_LDUR));
        expect_val("ldur_ext", SEL_EXT, 64'd0);
        expect_val("ldur_rd2_old", SEL_RD2, 64'd0);

        // ORR X5,X1,X31
        step(1'b0, 32'hAA1F_0025, 64'd0);
        expect_val("orr_rd1", SEL_RD1, 64'd20);
        expect_val("orr_rd2_xzr", SEL_RD2, 64'd0);
        expect_val("orr_ctrl", SEL_CTRL, 64'(C_R));

        // STUR X1,[X2,#-8]
        step(1'b0, 32'hF81F_8041, 64'd123);
        expect_val("stur_ctrl", SEL_CTRL, 64'(C_STUR));
        expect_val("stur_ext", SEL_EXT, 64'hFFFF_FFFF_FFFF_FFF8);
        expect_val("stur_rd2_rt", SEL_RD2, 64'd20);
        expect_val("stur_rd1", SEL_RD1, 64'd0);

        // CBZ X1,#-1
        step(1'b0, 32'hB4FF_FFE1, 64'd0);
        expect_val("cbz_ctrl", SEL_CTRL, 64'(C_CBZ));
        expect_val("cbz_ext", SEL_EXT, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_val("cbz_rd2_rt", SEL_RD2, 64'd20);

        // B #4 with a live write_data that must not be committed
        step(1'b0, 32'h1400_0004, 64'd77);
        expect_val("b_ctrl", SEL_CTRL, 64'(C_B));
        expect_val("b_ext", SEL_EXT, 64'd4);

        // ADD X31,X1,X1 with write_data=99: X1 intact after B, XZR write dropped
        step(1'b0, 32'h8B01_003F, 64'd99);
        expect_val("addxzr_rd1", SEL_RD1, 64'd20);
        expect_val("addxzr_rd2", SEL_RD2, 64'd20);

        // ORR X6,X31,X4: XZR still 0, X4 untouched by B
        step(1'b0, 32'hAA04_03E6, 64'd0);
        expect_val("xzr_read", SEL_RD1, 64'd0);
        expect_val("b_no_write_x4", SEL_RD2, 64'd0);

        // SUB X7,X1,X31 writes a wide pattern
        step(1'b0, 32'hCB1F_0027, 64'h1234_5678_9ABC_DEF0);
        expect_val("sub_ctrl", SEL_CTRL, 64'(C_R));

        // ORR X8,X7,X1 with reset raised: write of 55 must be discarded
        step(1'b1, 32'hAA01_00E8, 64'd55);
        expect_val("wide_rd1", SEL_RD1, 64'h1234_5678_9ABC_DEF0);
        expect_val("wide_rd2", SEL_RD2, 64'd20);
        expect_val("rst_ctrl_follow", SEL_CTRL, 64'(C_R));

        // AND X9,X8,X7 after reset: everything reads 0
        step(1'b0, 32'h8A07_0109, 64'd0);
        expect_val("post_rst_x8", SEL_RD1, 64'd0);
        expect_val("post_rst_x7", SEL_RD2, 64'd0);
        expect_val("and_ctrl", SEL_CTRL, 64'(C_R));

        // Near-miss of LDUR opcode decodes as unknown
        step(1'b0, 32'hF860_0021, 64'd5);
        expect_val("nearmiss_ctrl", SEL_CTRL, 64'(C_NONE));
        expect_val("nearmiss_ext", SEL_EXT, 64'd0);

        // Read X1 back: reset cleared it, near-miss did not write
        step(1'b0, 32'hAA01_0020, 64'd0);
        expect_val("post_rst_x1", SEL_RD1, 64'd0);

        step(1'b0, 32'h0000_0000, 64'd0);
        expect_val("zero_ctrl", SEL_CTRL, 64'(C_NONE));
        expect_val("zero_ext", SEL_EXT, 64'd0);

        step(1'b0, 32'h0000_0000, 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
